// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the round-robin FIFO drain arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_e;
  localparam int NUM_CH_DEF    = 4;
  localparam int DWIDTH_DEF    = 16;
  localparam int BURST_LEN_DEF = 4;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_next_sel.sv
// rr_next_sel: combinational round-robin picker, first requester after last_i (wrapping).
module rr_next_sel #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         any_o,
  output logic [W-1:0] next_o
);
  always_comb begin
    any_o  = |req_i;
    next_o = last_i;
    // Walk from farthest to nearest so the closest requester after last_i wins.
    for (int k = N; k >= 1; k--)
      if (req_i[(int'(last_i) + k) % N]) next_o = W'((int'(last_i) + k) % N);
  end
endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// fifo_rr_drain_arbiter: drains NUM_CH show-ahead FIFOs round-robin in bursts of up to
// BURST_LEN words into one registered valid/ready stream tagged with the source channel.
module fifo_rr_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_CH    = NUM_CH_DEF,
  parameter  int DWIDTH    = DWIDTH_DEF,
  parameter  int BURST_LEN = BURST_LEN_DEF,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic [NUM_CH-1:0]             fifo_empty_i,
  input  logic [NUM_CH-1:0][DWIDTH-1:0] fifo_q_i,
  output logic [NUM_CH-1:0]             fifo_rdreq_o,
  output logic [DWIDTH-1:0]             data_o,
  output logic [CH_W-1:0]               channel_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          busy_o
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d, last_q, last_d, next_ch;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              valid_q, valid_d, any_req, pop;

  rr_next_sel #(.N(NUM_CH), .W(CH_W)) u_sel (
    .req_i  (~fifo_empty_i),
    .last_i (last_q),
    .any_o  (any_req),
    .next_o (next_ch)
  );

  always_comb begin
    pop          = state_q == BURST && !fifo_empty_i[grant_q] && (!valid_q || ready_i);
    fifo_rdreq_o = pop ? NUM_CH'(1) << grant_q : '0;
    // An empty granted FIFO ends the burst at once rather than waiting for more data.
    state_d = state_q == IDLE ? (any_req ? BURST : IDLE)
            : (fifo_empty_i[grant_q] || (pop && cnt_q == CNT_W'(BURST_LEN - 1))) ? IDLE : BURST;
    grant_d = (state_q == IDLE && any_req) ? next_ch : grant_q;
    last_d  = (state_q == IDLE && any_req) ? next_ch : last_q;
    cnt_d   = state_q == IDLE ? '0 : pop ? cnt_q + CNT_W'(1) : cnt_q;
    valid_d = pop ? 1'b1 : ready_i ? 1'b0 : valid_q;
    data_d  = pop ? fifo_q_i[grant_q] : data_q;
    ch_d    = pop ? grant_q : ch_q;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign data_o    = data_q;
  assign channel_o = ch_q;
  assign valid_o   = valid_q;
  assign busy_o    = state_q == BURST;
endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// tb_fifo_rr_drain_arbiter: directed bench with queue-modelled show-ahead FIFOs and an output scoreboard.
module tb_fifo_rr_drain_arbiter;
  logic             clk_i = 1'b0;
  logic             arst_n_i = 1'b0;
  logic [3:0]       fifo_empty_i = 4'hf;
  logic [3:0][15:0] fifo_q_i = '0;
  logic [3:0]       fifo_rdreq_o;
  logic [15:0]      data_o;
  logic [1:0]       channel_o;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic             busy_o;

  logic [15:0] fq[4][$];
  logic [31:0] rx_w[$];
  int          rx_c[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  fifo_rr_drain_arbiter dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .data_o       (data_o),
    .channel_o    (channel_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int ch, input int i);
    return 32'((ch << 16) | (ch * 'h1000 + i));
  endfunction

  // FIFO model: pop on rdreq at the edge, present the new head shortly after.
  always @(posedge clk_i) begin
    if (valid_o && ready_i) begin
      rx_w.push_back({14'b0, channel_o, data_o});
      rx_c.push_back(cyc);
    end
    for (int c = 0; c < 4; c++)
      if (fifo_rdreq_o[c]) begin
        chk("rdreq_on_empty", {31'b0, fifo_empty_i[c]}, 32'd0);
        if (fq[c].size() > 0) void'(fq[c].pop_front());
      end
    cyc++;
    #1;
    for (int c = 0; c < 4; c++) begin
      fifo_empty_i[c] = fq[c].size() == 0;
      fifo_q_i[c]     = fq[c].size() > 0 ? fq[c][0] : 16'h0;
    end
  end

  task automatic load(input int ch, input int n);
    for (int i = 0; i < n; i++) fq[ch].push_back(16'(ch * 'h1000 + i));
  endtask

  task automatic start_reset();
    @(negedge clk_i);
    arst_n_i = 1'b0;
    ready_i  = 1'b1;
    for (int c = 0; c < 4; c++) fq[c].delete();
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk_i);
    rx_w.delete();
    rx_c.delete();
    arst_n_i = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_w.size() < n && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    chk("wait_timeout", rx_w.size() >= n, 32'd1);
  endtask

  initial begin
    // Reset held with all FIFOs non-empty, then round robin over 4 full channels.
    start_reset();
    for (int c = 0; c < 4; c++) load(c, 8);
    repeat (3) @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_rdreq", fifo_rdreq_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_chan", channel_o, 0);
    release_reset();
    #1;
    chk("rel_idle_rdreq", fifo_rdreq_o, 0);
    chk("rel_idle_busy", busy_o, 0);
    @(negedge clk_i);
    chk("first_grant_rdreq", fifo_rdreq_o, 4'b0001);
    chk("first_grant_busy", busy_o, 1);
    wait_rx(32, 300);
    for (int k = 0; k < 32 && k < rx_w.size(); k++)
      chk($sformatf("rr_word%0d", k), rx_w[k], word((k / 4) % 4, (k / 16) * 4 + k % 4));
    if (rx_c.size() >= 32) begin
      chk("rr_back_to_back", rx_c[1] - rx_c[0], 1);
      chk("rr_one_bubble", rx_c[4] - rx_c[0], 5);
      chk("rr_total_span", rx_c[31] - rx_c[0], 38);
    end

    // Early burst end: channel 1 holds only 2 words.
    start_reset();
    load(1, 2);
    release_reset();
    wait_rx(2, 20);
    for (int k = 0; k < 2 && k < rx_w.size(); k++) chk($sformatf("early_word%0d", k), rx_w[k], word(1, k));
    repeat (5) @(negedge clk_i);
    chk("early_count", rx_w.size(), 2);
    chk("early_busy", busy_o, 0);
    chk("early_rdreq", fifo_rdreq_o, 0);

    // Backpressure mid-burst: output must hold, no pops, no loss on resume.
    start_reset();
    load(0, 4);
    release_reset();
    wait_rx(2, 20);
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("bp_data", data_o, 16'h0002);
      chk("bp_chan", channel_o, 0);
      chk("bp_valid", valid_o, 1);
      chk("bp_rdreq", fifo_rdreq_o, 0);
      chk("bp_busy", busy_o, 1);
    end
    ready_i = 1'b1;
    wait_rx(4, 20);
    repeat (4) @(negedge clk_i);
    chk("bp_count", rx_w.size(), 4);
    for (int k = 0; k < 4 && k < rx_w.size(); k++) chk($sformatf("bp_word%0d", k), rx_w[k], word(0, k));

    // Skip empty channels: only 0 and 3 have data.
    start_reset();
    load(0, 8);
    load(3, 8);
    release_reset();
    wait_rx(16, 200);
    for (int k = 0; k < 16 && k < rx_w.size(); k++)
      chk($sformatf("skip_word%0d", k), rx_w[k], word(((k / 4) % 2) * 3, (k / 8) * 4 + k % 4));

    // Asynchronous reset mid-burst on channel 2, then channel 0 must win first.
    start_reset();
    load(2, 8);
    release_reset();
    wait_rx(1, 20);
    chk("ar_busy_before", busy_o, 1);
    #2;
    arst_n_i = 1'b0;
    #1;
    chk("ar_valid", valid_o, 0);
    chk("ar_data", data_o, 0);
    chk("ar_chan", channel_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_rdreq", fifo_rdreq_o, 0);
    load(0, 2);
    release_reset();
    @(negedge clk_i);
    chk("ar_regrant_ch0", fifo_rdreq_o, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
